sha2blkser: RTL
===============

# sha2blkser

Block serializer for the SHA-2 input path, running in the opposite direction to the packet packer. It accepts a complete 512-bit message block in one handshake and streams it back out as eight 64-bit packets over a valid/ready interface, word 0 first. On the final block of a message it flags the length word and captures its value. It sits between the packed-block register file and any 64-bit consumer, such as the message-schedule loader or a debug/export port.

## Interface
- `reg_w`, 64, packet/word width in bits
- `reg_cnt`, 8, words per block
- `dec_w`, 3, index width; `2**dec_w` must equal `reg_cnt`

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_b`  in  1  reset, synchronous and active-low
- `clr`  in  1  synchronous abort: return to IDLE, zero the index
- `blk`  in  reg_cnt*reg_w  block to serialize; word i is `blk[i*reg_w +: reg_w]`
- `blk_vld`  in  1  `blk` and `fin_blk` are valid
- `fin_blk`  in  1  block is the last of its message; word reg_cnt-1 holds the message length
- `blk_rdy`  out  1  serializer can accept a block this cycle
- `pkt`  out  reg_w  current output word
- `pkt_vld`  out  1  `pkt` is valid
- `pkt_rdy`  in  1  consumer accepts `pkt`
- `idx`  out  dec_w  index of the word currently on `pkt`
- `mgln_pkt`  out  1  current beat is the message-length word
- `msg_len`  out  reg_w  last message length sent

## Operation
- There are two states, IDLE and SEND. Internal storage: block register (reg_cnt*reg_w), `fin` flag, `idx` counter, `msg_len` register.
- IDLE:
  - `blk_rdy`=1 and `pkt_vld`=0.
  - If `blk_vld` is high, capture `blk` and `fin_blk`, set `idx`=0, and go to SEND.
- SEND:
  - `pkt_vld`=1 and `pkt` = stored word[`idx`].
  - `mgln_pkt` = `fin` & (`idx`==reg_cnt-1).
  - Each `pkt_vld & pkt_rdy` beat increments `idx`.
  - On the beat with `idx`==reg_cnt-1: `idx` wraps to 0 and the state returns to IDLE. If `mgln_pkt` is set, `msg_len` loads that word.
- Stall rule: while `pkt_rdy`=0, `pkt`, `idx` and `mgln_pkt` hold stable. `pkt_vld` never deasserts before its handshake.
- `blk_vld` seen in SEND is ignored, with `blk_rdy`=0. The exception is the bypass case under Configuration.
- Priority on each edge: `rst_b`=0 first, then `clr`=1, then the handshakes.
  - `clr` mid-block drops the remaining words.
  - `clr` leaves `msg_len` unchanged.
  - `clr` and `blk_vld` in the same cycle: the block is not captured.
- Reset values, after an edge with `rst_b`=0:
  - state IDLE
  - `idx`=0, `pkt_vld`=0, `mgln_pkt`=0
  - `msg_len`=0, `pkt`=0 (block register cleared)
  - `blk_rdy` is forced to 0 while `rst_b`=0.

## Timing
- Block accepted at edge N: first packet is valid in the cycle after N (`pkt_vld` registered from state). Latency is 1 cycle.
- With `pkt_rdy` held at 1, the 8 packets occupy 8 consecutive cycles.
- Block throughput without bypass: one block per 9 cycles (1 IDLE cycle plus 8 SEND cycles).
- `idx`, `pkt` and `mgln_pkt` are functions of registered state only.
- `blk_rdy` is registered-state-derived, except in bypass mode.

## Configuration
- Macro: `SHA2BLKSER_BYPASS_EN`.
- Defined:
  - `blk_rdy` = IDLE | (SEND & `idx`==reg_cnt-1 & `pkt_rdy`). This is a combinational path from `pkt_rdy` to `blk_rdy`.
  - A block accepted on the last beat loads immediately. The state stays SEND with `idx`=0.
  - Throughput is one block per 8 cycles.
- Undefined: `blk_rdy` is IDLE only, with the mandatory 1-cycle bubble between blocks.

## Test plan
- **Reset:** hold `rst_b`=0 for 2 edges with `blk_vld`=1 → `blk_rdy`=0, `pkt_vld`=0, `idx`=0, `msg_len`=0; no capture.
- **Basic serialize:**
  - Stimulus: `blk` word i = 64'h1111_0000_0000_0000*i+i, `fin_blk`=0, `pkt_rdy`=1.
  - Expected: 8 beats with `idx` 0..7 and `pkt` equal to word `idx`, `mgln_pkt`=0 throughout, back to IDLE after beat 7.
- **Backpressure:** toggle `pkt_rdy` 1,0,0,1 repeatedly → every word is emitted exactly once in order; `pkt` and `idx` are stable during stalls.
- **Final block:** `fin_blk`=1 with word 7 = 64'h0000_0000_0000_0180 → `mgln_pkt`=1 only on `idx`=7; `msg_len`=64'h180 after that handshake.
- **Abort:** `clr`=1 at `idx`=3 → next cycle IDLE, `idx`=0, `pkt_vld`=0, `msg_len` unchanged. The next block starts from word 0.
- **Back-to-back blocks:** two blocks, `blk_vld` held high, `pkt_rdy`=1 → 17 cycles from first accept to last beat without the macro, 16 with `SHA2BLKSER_BYPASS_EN`. No words are lost or duplicated.

Source files
------------

// File: rtl/sha2blkser.sv
// SHA-2 block serializer: takes one 512-bit block per handshake and streams it out as eight 64-bit packets.
// Define SHA2BLKSER_BYPASS_EN to accept the next block on the last beat, removing the idle bubble between blocks.
module sha2blkser #(
  parameter int reg_w   = 64,
  parameter int reg_cnt = 8,
  parameter int dec_w   = 3
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     clr,
  input  logic [reg_cnt*reg_w-1:0] blk,
  input  logic                     blk_vld,
  input  logic                     fin_blk,
  output logic                     blk_rdy,
  output logic [reg_w-1:0]         pkt,
  output logic                     pkt_vld,
  input  logic                     pkt_rdy,
  output logic [dec_w-1:0]         idx,
  output logic                     mgln_pkt,
  output logic [reg_w-1:0]         msg_len
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds, with its data stable, until that transfer occurs.

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [dec_w-1:0] last_idx = dec_w'(reg_cnt - 1);

  state_t                        state;
  logic [reg_cnt-1:0][reg_w-1:0] words;
  logic                          fin;
  logic                          beat;
  logic                          last_beat;
  logic                          capture;

  assign pkt_vld   = (state == SEND);
  assign pkt       = words[idx];
  assign mgln_pkt  = pkt_vld & fin & (idx == last_idx);
  assign beat      = pkt_vld & pkt_rdy;
  assign last_beat = beat & (idx == last_idx);

`ifdef SHA2BLKSER_BYPASS_EN
  // Combinational pkt_rdy -> blk_rdy path lets a new block replace the old one on its final beat.
  assign blk_rdy = rst_b & ((state == IDLE) | last_beat);
`else
  assign blk_rdy = rst_b & (state == IDLE);
`endif

  assign capture = blk_vld & blk_rdy & ~clr;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state   <= IDLE;
      words   <= '0;
      fin     <= 1'b0;
      idx     <= '0;
      msg_len <= '0;
    end else if (clr) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      if (beat) begin
        idx <= last_beat ? '0 : idx + 1'b1;
        if (mgln_pkt) msg_len <= pkt;
        if (last_beat) state <= IDLE;
      end
      // A capture on the final beat (bypass) overrides the return to IDLE.
      if (capture) begin
        words <= blk;
        fin   <= fin_blk;
        idx   <= '0;
        state <= SEND;
      end
    end
  end

endmodule
